// File: rtl/multicycle_processor.sv
// Multicycle RV32I-subset core: one shared memory port with a ready handshake and a
// single ALU reused for PC increment, effective addresses and branch/jump targets.
module multicycle_processor #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned RET_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_ready,
    output logic [31:0]      PC,
    output logic             halted,
    output logic [RET_W-1:0] retired
);
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXEC_R, S_EXEC_I, S_ALUWB, S_BRANCH, S_JAL, S_LUI, S_HALT
    } state_t;

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;

    state_t      state, next_state;
    logic [31:0] ir, old_pc, a, b, alu_out, data, target;
    logic [31:0] regs [32];

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
    logic        arith_f3, r_legal, i_legal;

    alu_op_t     alu_op;
    logic [31:0] alu_a, alu_b, alu_y;
    logic        taken, retire, wr_en;
    logic [31:0] wr_data;

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign funct3 = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign funct7 = ir[31:25];
    assign imm_i  = {{20{ir[31]}}, ir[31:20]};
    assign imm_s  = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b  = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_j  = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
    assign imm_u  = {ir[31:12], 12'b0};

    assign arith_f3 = (funct3 == 3'b000) || (funct3 == 3'b111) || (funct3 == 3'b110) || (funct3 == 3'b010);
    assign r_legal  = (funct7 == 7'h00 && arith_f3) || (funct7 == 7'h20 && funct3 == 3'b000);
    assign i_legal  = arith_f3;
    assign halted   = (state == S_HALT);

    function automatic alu_op_t op_from(input logic [2:0] f3, input logic sub);
        case (f3)
            3'b000:  return sub ? ALU_SUB : ALU_ADD;
            3'b111:  return ALU_AND;
            3'b110:  return ALU_OR;
            default: return ALU_SLT;
        endcase
    endfunction

    always_comb begin
        case (alu_op)
            ALU_SUB: alu_y = alu_a - alu_b;
            ALU_AND: alu_y = alu_a & alu_b;
            ALU_OR:  alu_y = alu_a | alu_b;
            ALU_SLT: alu_y = {31'b0, $signed(alu_a) < $signed(alu_b)};
            default: alu_y = alu_a + alu_b;
        endcase
    end

    always_comb begin
        next_state = state;
        alu_a      = a;
        alu_b      = b;
        alu_op     = ALU_ADD;
        taken      = 1'b0;
        retire     = 1'b0;
        wr_en      = 1'b0;
        wr_data    = alu_out;
        case (state)
            S_FETCH: begin
                alu_a = PC;
                alu_b = 32'd4;
                if (mem_ready) next_state = S_DECODE;
            end
            S_DECODE: begin
                alu_a = old_pc;
                alu_b = (opcode == OP_JAL) ? imm_j : imm_b;
                case (opcode)
                    OP_LW, OP_SW: next_state = (funct3 == 3'b010) ? S_MEMADR : S_HALT;
                    OP_R:         next_state = r_legal ? S_EXEC_R : S_HALT;
                    OP_I:         next_state = i_legal ? S_EXEC_I : S_HALT;
                    OP_BR:        next_state = (funct3[2:1] == 2'b00) ? S_BRANCH : S_HALT;
                    OP_JAL:       next_state = S_JAL;
                    OP_LUI:       next_state = S_LUI;
                    default:      next_state = S_HALT;
                endcase
            end
            S_MEMADR: begin
                alu_b = (opcode == OP_SW) ? imm_s : imm_i;
                if (alu_y[1:0] != 2'b00) next_state = S_HALT;
                else                     next_state = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: if (mem_ready) next_state = S_MEMWB;
            S_MEMWB: begin
                wr_en      = 1'b1;
                wr_data    = data;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_MEMWRITE: if (mem_ready) begin
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_EXEC_R: begin
                alu_op     = op_from(funct3, funct7[5]);
                next_state = S_ALUWB;
            end
            S_EXEC_I: begin
                alu_b      = imm_i;
                alu_op     = op_from(funct3, 1'b0);
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                wr_en      = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_BRANCH: begin
                alu_op = ALU_SUB;
                taken  = funct3[0] ? (alu_y != '0) : (alu_y == '0);
                if (taken && target[1:0] != 2'b00) next_state = S_HALT;
                else begin
                    retire     = 1'b1;
                    next_state = S_FETCH;
                end
            end
            // Link value goes through ALUOut so the shared writeback state commits rd.
            S_JAL: begin
                alu_a      = old_pc;
                alu_b      = 32'd4;
                next_state = (target[1:0] != 2'b00) ? S_HALT : S_ALUWB;
            end
            S_LUI: begin
                wr_en      = 1'b1;
                wr_data    = imm_u;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            default: next_state = S_HALT;
        endcase
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (reset) begin
            case (state)
                S_FETCH: begin
                    mem_req  = 1'b1;
                    mem_addr = PC;
                end
                S_MEMREAD: begin
                    mem_req  = 1'b1;
                    mem_addr = alu_out;
                end
                S_MEMWRITE: begin
                    mem_req   = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = alu_out;
                    mem_wdata = b;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= S_FETCH;
            PC      <= RESET_PC;
            ir      <= '0;
            old_pc  <= '0;
            a       <= '0;
            b       <= '0;
            alu_out <= '0;
            data    <= '0;
            target  <= '0;
            retired <= '0;
            for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            state <= next_state;
            case (state)
                S_FETCH: if (mem_ready) begin
                    ir     <= mem_rdata;
                    old_pc <= PC;
                    PC     <= alu_y;
                end
                S_DECODE: begin
                    a      <= regs[rs1];
                    b      <= regs[rs2];
                    target <= alu_y;
                end
                S_MEMADR, S_EXEC_R, S_EXEC_I: alu_out <= alu_y;
                S_JAL: begin
                    alu_out <= alu_y;
                    PC      <= target;
                end
                S_MEMREAD: if (mem_ready) data <= mem_rdata;
                S_BRANCH: if (taken) PC <= target;
                default: ;
            endcase
            if (wr_en && rd != 5'd0) regs[rd] <= wr_data;
            if (retire) retired <= retired + RET_W'(1);
            // Faults always report the address of the offending instruction.
            if (next_state == S_HALT && state != S_HALT) PC <= old_pc;
        end
    end

endmodule

// File: tb/tb_multicycle_processor.sv
// Scoreboard bench: an ISA-level reference model predicts every memory transaction and
// the halt state; a monitor pops and compares each accepted access.
module tb_multicycle_processor;
    localparam logic [31:0] RPC = 32'h100;
    localparam int unsigned RW  = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          mem_req, mem_we, mem_ready, halted;
    logic [31:0]   mem_addr, mem_wdata, mem_rdata, PC;
    logic [RW-1:0] retired;

    multicycle_processor #(.RESET_PC(RPC), .RET_W(RW)) dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .PC(PC), .halted(halted), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } xact_t;

    xact_t       exp_q[$];
    logic [31:0] img [256];
    logic [31:0] mem [256];
    logic [31:0] mm  [256];
    logic [31:0] rf  [32];
    logic [31:0] exp_pc;
    logic [31:0] exp_ret;
    int unsigned wp;
    int unsigned wait_max = 0;
    bit          fixed_wait = 1'b1;
    int unsigned wcnt = 0, wtarget = 0;
    bit          noise = 1'b0;
    int          checks = 0, errors = 0;

    // Memory with programmable wait states; ready outside a request is random noise.
    assign mem_ready = mem_req ? (wcnt >= wtarget) : noise;
    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        noise <= ($urandom_range(3, 0) == 0);
        if (!reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= img[i];
            wcnt    <= 0;
            wtarget <= fixed_wait ? wait_max : $urandom_range(wait_max, 0);
        end else if (mem_req && mem_ready) begin
            if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
            wcnt    <= 0;
            wtarget <= fixed_wait ? wait_max : $urandom_range(wait_max, 0);
        end else if (mem_req) begin
            wcnt <= wcnt + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] r_t(input int unsigned k, input logic [4:0] rd, input logic [4:0] s1, input logic [4:0] s2);
        logic [6:0] f7;
        logic [2:0] f3;
        f7 = (k == 1) ? 7'h20 : 7'h00;
        case (k)
            0, 1:    f3 = 3'd0;
            2:       f3 = 3'd7;
            3:       f3 = 3'd6;
            default: f3 = 3'd2;
        endcase
        return {f7, s2, s1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] i_t(input logic [11:0] imm, input logic [2:0] f3, input logic [4:0] rd, input logic [4:0] s1);
        return {imm, s1, f3, rd, 7'h13};
    endfunction

    function automatic logic [31:0] lw_t(input logic [11:0] imm, input logic [4:0] rd, input logic [4:0] s1);
        return {imm, s1, 3'b010, rd, 7'h03};
    endfunction

    function automatic logic [31:0] sw_t(input logic [11:0] imm, input logic [4:0] s2, input logic [4:0] s1);
        return {imm[11:5], s2, s1, 3'b010, imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] b_t(input logic [12:0] imm, input logic [2:0] f3, input logic [4:0] s1, input logic [4:0] s2);
        return {imm[12], imm[10:5], s2, s1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] j_t(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
    endfunction

    task automatic clear_img();
        for (int i = 0; i < 256; i++) img[i] = 32'h0;
        wp = RPC >> 2;
    endtask

    task automatic put(input logic [31:0] w);
        img[wp] = w;
        wp++;
    endtask

    // Instruction-set-level execution of img: queues expected accesses and final state.
    task automatic model_run();
        logic [31:0] pc, ir, x, y, ea, v, t, npc;
        logic [31:0] immi, imms, immb, immj;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        bit          stop, ok, wr;
        int unsigned ret;
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        for (int i = 0; i < 256; i++) mm[i] = img[i];
        pc = RPC; ret = 0; stop = 1'b0;
        for (int n = 0; n < 2000 && !stop; n++) begin
            ir = mm[pc[9:2]];
            exp_q.push_back('{addr: pc, we: 1'b0, wdata: 32'h0});
            x = rf[ir[19:15]]; y = rf[ir[24:20]];
            f3 = ir[14:12]; f7 = ir[31:25]; rd = ir[11:7];
            immi = {{20{ir[31]}}, ir[31:20]};
            imms = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            immb = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            immj = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            ok = 1'b1; wr = 1'b0; v = 32'h0; npc = pc + 4;
            case (ir[6:0])
                7'h33, 7'h13: begin
                    if (ir[6:0] == 7'h13) y = immi;
                    if (!(f3 inside {3'd0, 3'd7, 3'd6, 3'd2})) ok = 1'b0;
                    if (ir[6:0] == 7'h33 && !(f7 == 7'h00 || (f7 == 7'h20 && f3 == 3'd0))) ok = 1'b0;
                    wr = 1'b1;
                    case (f3)
                        3'd0:    v = (ir[6:0] == 7'h33 && f7 == 7'h20) ? x - y : x + y;
                        3'd7:    v = x & y;
                        3'd6:    v = x | y;
                        default: v = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
                    endcase
                end
                7'h03: begin
                    ea = x + immi;
                    if (f3 != 3'd2 || ea % 4 != 0) ok = 1'b0;
                    else begin
                        exp_q.push_back('{addr: ea, we: 1'b0, wdata: 32'h0});
                        v = mm[ea[9:2]]; wr = 1'b1;
                    end
                end
                7'h23: begin
                    ea = x + imms;
                    if (f3 != 3'd2 || ea % 4 != 0) ok = 1'b0;
                    else begin
                        exp_q.push_back('{addr: ea, we: 1'b1, wdata: y});
                        mm[ea[9:2]] = y;
                    end
                end
                7'h63: begin
                    if (f3 > 3'd1) ok = 1'b0;
                    else if ((x == y) == (f3 == 3'd0)) begin
                        t = pc + immb;
                        if (t % 4 != 0) ok = 1'b0; else npc = t;
                    end
                end
                7'h6f: begin
                    t = pc + immj;
                    if (t % 4 != 0) ok = 1'b0;
                    else begin v = pc + 4; wr = 1'b1; npc = t; end
                end
                7'h37: begin v = {ir[31:12], 12'h000}; wr = 1'b1; end
                default: ok = 1'b0;
            endcase
            if (!ok) stop = 1'b1;
            else begin
                if (wr && rd != 0) rf[rd] = v;
                ret++;
                pc = npc;
            end
        end
        exp_pc  = pc;
        exp_ret = ret % (1 << RW);
    endtask

    task automatic gen_random();
        int unsigned k;
        clear_img();
        for (int i = 0; i < 64; i++) img[i] = $urandom;
        for (int r = 1; r < 8; r++) put(i_t(12'($urandom), 3'd0, 5'(r), 5'd0));
        repeat (30) begin
            k = $urandom_range(9, 0);
            case (k)
                0, 1, 2: put(r_t($urandom_range(4, 0), 5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)), 5'($urandom_range(7, 0))));
                3, 4: put(i_t(12'($urandom), 3'(($urandom_range(3, 0) == 0) ? 2 : 6 + $urandom_range(1, 0)),
                              5'($urandom_range(7, 0)), 5'($urandom_range(7, 0))));
                5: put(lw_t(12'(4 * $urandom_range(31, 0)), 5'($urandom_range(7, 0)), 5'd0));
                6: put(sw_t(12'(4 * $urandom_range(31, 0)), 5'($urandom_range(7, 0)), 5'd0));
                7, 8: begin
                    if (k == 7) put(b_t(13'd8, 3'($urandom_range(1, 0)), 5'($urandom_range(7, 0)), 5'($urandom_range(7, 0))));
                    else        put(j_t(21'd8, 5'($urandom_range(7, 0))));
                    put(r_t(0, 5'($urandom_range(7, 1)), 5'($urandom_range(7, 0)), 5'($urandom_range(7, 0))));
                end
                default: put({20'($urandom), 5'($urandom_range(7, 0)), 7'h37});
            endcase
        end
        for (int r = 1; r < 8; r++) put(sw_t(12'(4 * (32 + r)), 5'(r), 5'd0));
        put(32'h0);
    endtask

    task automatic monitor();
        xact_t e, prev;
        bit    have;
        have = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (!reset || !mem_req) have = 1'b0;
            else begin
                if (have) begin
                    chk("hold_addr", mem_addr, prev.addr);
                    chk("hold_we", 32'(mem_we), 32'(prev.we));
                    chk("hold_wdata", mem_wdata, prev.wdata);
                end
                if (mem_ready) begin
                    have = 1'b0;
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_access got addr %h want none", mem_addr);
                    end else begin
                        e = exp_q.pop_front();
                        chk("acc_addr", mem_addr, e.addr);
                        chk("acc_we", 32'(mem_we), 32'(e.we));
                        if (e.we) chk("acc_wdata", mem_wdata, e.wdata);
                    end
                end else begin
                    prev = '{addr: mem_addr, we: mem_we, wdata: mem_wdata};
                    have = 1'b1;
                end
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_pc", PC, RPC);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_retired", 32'(retired), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("first_req", 32'(mem_req), 32'd1);
        chk("first_addr", mem_addr, RPC);
    endtask

    task automatic start(input int unsigned wmax, input bit fixed);
        wait_max   = wmax;
        fixed_wait = fixed;
        exp_q.delete();
        model_run();
        do_reset();
    endtask

    // Counts rising edges (from reset release) until retired reaches tgt.
    task automatic check_cycles(input string nm, input logic [RW-1:0] tgt, input int unsigned want);
        int unsigned n;
        n = 0;
        while (retired != tgt && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk(nm, n, want);
    endtask

    task automatic finish_prog(input string nm);
        int unsigned n;
        n = 0;
        while (!halted && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_halted"}, 32'(halted), 32'd1);
        repeat (3) @(negedge clk);
        chk({nm, "_pc"}, PC, exp_pc);
        chk({nm, "_retired"}, 32'(retired), exp_ret);
        chk({nm, "_req"}, 32'(mem_req), 32'd0);
        chk({nm, "_pending"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        fork
            monitor();
        join_none

        // Zero-wait straight-line program: 4+4+4+4+5 cycles to the fifth retirement.
        clear_img();
        put(i_t(12'd5, 3'd0, 5'd1, 5'd0));
        put(i_t(12'd7, 3'd0, 5'd2, 5'd0));
        put(r_t(0, 5'd3, 5'd1, 5'd2));
        put(sw_t(12'd0, 5'd3, 5'd0));
        put(lw_t(12'd0, 5'd4, 5'd0));
        put(sw_t(12'd4, 5'd4, 5'd0));
        put(32'h0);
        start(0, 1'b1);
        chk("model_x4", rf[4], 32'd12);
        check_cycles("zero_wait_cycles", 4'd5, 21);
        finish_prog("zero_wait");

        // Three wait cycles on every access: lw takes 11 cycles.
        clear_img();
        img[0] = 32'hdead_beef;
        put(lw_t(12'd0, 5'd4, 5'd0));
        put(sw_t(12'd8, 5'd4, 5'd0));
        put(32'h0);
        start(3, 1'b1);
        check_cycles("lw_wait_cycles", 4'd1, 11);
        finish_prog("lw_wait");

        // Taken beq skips an illegal word; jal links and jumps; x0 write discarded.
        clear_img();
        put(b_t(13'd8, 3'd0, 5'd0, 5'd0));
        put(32'h0);
        put(j_t(21'd16, 5'd1));
        put(32'h0); put(32'h0); put(32'h0);
        put(i_t(12'd9, 3'd0, 5'd0, 5'd0));
        put(sw_t(12'd0, 5'd1, 5'd0));
        put(sw_t(12'd4, 5'd0, 5'd0));
        put(32'h0);
        start(0, 1'b1);
        chk("model_link", rf[1], 32'h10c);
        check_cycles("beq_cycles", 4'd1, 3);
        finish_prog("branch_jal");

        // Misaligned load halts at the faulting instruction.
        clear_img();
        put(lw_t(12'd2, 5'd5, 5'd0));
        start(1, 1'b0);
        finish_prog("halt_lw");

        // Misaligned jal and taken bne targets.
        clear_img();
        put(j_t(21'd6, 5'd3));
        start(0, 1'b1);
        finish_prog("halt_jal");
        clear_img();
        put(i_t(12'd1, 3'd0, 5'd1, 5'd0));
        put(b_t(13'd6, 3'd1, 5'd1, 5'd0));
        start(2, 1'b0);
        finish_prog("halt_bne");

        // Seventeen retirements wrap the 4-bit counter to 1.
        clear_img();
        repeat (16) put(i_t(12'd1, 3'd0, 5'd1, 5'd1));
        put(sw_t(12'd0, 5'd1, 5'd0));
        put(32'h0);
        start(0, 1'b1);
        finish_prog("wrap");
        chk("wrap_value", 32'(retired), 32'd1);

        // Aborted run: reset lands mid-instruction, possibly mid-wait.
        gen_random();
        start(3, 1'b0);
        repeat ($urandom_range(80, 20)) @(negedge clk);

        for (int t = 0; t < 6; t++) begin
            gen_random();
            start(t % 4, 1'b0);
            finish_prog("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/multicycle_processor.md
# multicycle_processor

Parametrised multicycle RV32I-subset core, the next generation of the team's single-cycle processor. Replaces separate instruction/data memories with one shared memory port carrying a request/ready handshake, so external memory may insert wait states. A control FSM sequences each instruction over 3–5 cycles, reusing one ALU for PC increment, address and branch computation. Adds a configurable reset vector, a retired-instruction counter and a sticky halt on illegal or misaligned operations.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- RET_W, 32, width of retired-instruction counter
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- mem_req  output  1  memory request valid
- mem_we  output  1  1 = write (sw), 0 = read
- mem_addr  output  32  word address (bits [1:0] always 0)
- mem_wdata  output  32  store data
- mem_rdata  input  32  read data, valid in the cycle mem_ready is high on a read
- mem_ready  input  1  request accepted/completed this cycle
- PC  output  32  current instruction address
- halted  output  1  sticky halt flag
- retired  output  RET_W  count of completed instructions

## Operation
- Supported: lw, sw, add, sub, and, or, slt, addi, andi, ori, slti, beq, bne, jal, lui. Any other opcode/funct → HALT.
- Architectural regs: 32×32 file, x0 reads 0, writes to x0 discarded; file cleared to 0 on reset.
- FSM states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXEC_R, EXEC_I, ALUWB, BRANCH, JAL, LUI, HALT.
- FETCH: mem_req=1, mem_we=0, mem_addr=PC; on mem_ready latch IR←mem_rdata, OldPC←PC, PC←PC+4, go DECODE. Stay in FETCH while mem_ready=0.
- DECODE: read rs1/rs2 into A/B, compute OldPC+imm into target register; dispatch on opcode.
- MEMADR: ALUOut←A+immI/immS; if ALUOut[1:0]≠0 → HALT; else lw→MEMREAD, sw→MEMWRITE.
- MEMREAD: read request at ALUOut; on mem_ready latch Data, go MEMWB. MEMWB: rd←Data, retire, FETCH.
- MEMWRITE: mem_we=1, mem_wdata=B; on mem_ready retire, FETCH.
- EXEC_R/EXEC_I: ALUOut←A op B / A op immI; go ALUWB. ALUWB: rd←ALUOut, retire, FETCH.
- BRANCH: compare A,B; taken (beq equal / bne unequal) → PC←target; target[1:0]≠0 when taken → HALT; else retire, FETCH.
- JAL: rd←OldPC+4, PC←target; target[1:0]≠0 → HALT without writing rd; else retire, FETCH.
- LUI: rd←{imm[31:12],12'b0}, retire, FETCH.
- HALT: mem_req=0, halted=1, PC frozen at faulting instruction's OldPC, retired frozen; exit only by reset.
- slt/slti signed compare; all arithmetic modulo 2^32; retired wraps modulo 2^RET_W.
- mem_addr/mem_we/mem_wdata held stable while mem_req=1 and mem_ready=0.

## Timing
- Reset (reset=0 at a rising edge): PC=RESET_PC, state=FETCH, mem_req=0 during reset cycle, mem_we=0, mem_addr=0, mem_wdata=0, halted=0, retired=0, regs=0. Reset mid-instruction or mid-wait abandons the access with no register/memory side effect beyond already-completed writes.
- First cycle after reset released: FETCH with mem_req=1.
- mem_ready sampled at the rising edge in which mem_req=1; combinational same-cycle ready allowed (zero-wait).
- Zero-wait CPI: beq/bne 3, lui 3, R-type 4, I-type 4, jal 4, sw 4, lw 5. Each wait cycle on FETCH/MEMREAD/MEMWRITE adds exactly one cycle.
- Register write and retired increment take effect at the edge ending the writeback state; next FETCH sees new value.
- mem_ready asserted while mem_req=0 is ignored.

## Test plan
- Reset: RESET_PC=32'h100, hold reset=0 two cycles → PC=32'h100, mem_req=0, retired=0; release → mem_req=1, mem_addr=32'h100.
- Zero-wait program addi x1,x0,5; addi x2,x0,7; add x3,x1,x2; sw x3,0(x0); lw x4,0(x0) → x3=12, memory[0]=12, x4=12, retired=5 after 4+4+4+4+5=21 cycles.
- Wait states: mem_ready low 3 cycles on every access during lw → lw takes 5+6=11 cycles, mem_addr/mem_we stable throughout, result unchanged.
- Branch/jump: beq x0,x0,+8 from PC 0 → PC=8 after 3 cycles; jal x1,+16 at PC 8 → x1=12, PC=24; addi x0,x0,9 → x0 stays 0.
- Halt: lw x5,2(x0) → halted=1 after MEMADR, mem_req=0, PC=faulting address, retired unchanged; opcode 7'b0000000 also halts; reset clears halted.
- Counter wrap: RET_W=4, execute 17 instructions → retired=1.
